// File: rtl/mem_access_ctrl.sv
// Memory-interface stage between the CPU bus and a 512x32 RAM: holds MAR and the
// write-data register, sequences read/write strobes with optional wait states.
module mem_access_ctrl #(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req,
    input  logic              we,
    input  logic [31:0]       addr_in,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              addr_err,
    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_ACCESS = 3'd2,
        S_DONE   = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic       NO_WAIT   = (WAIT_CYCLES == 0);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   mar_q, mar_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                op_q, op_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                addr_err_q, addr_err_d;
    logic                busy_q, done_q, ram_read_q, ram_write_q;
    logic                addr_oor_s;

    // Any bit set above the RAM word-address range makes the request malformed.
    assign addr_oor_s = ((addr_in >> ADDR_W) != 32'd0);

    // Next-state and datapath-register update logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mar_d      = mar_q;
        wdata_d    = wdata_q;
        op_d       = op_q;
        rdata_d    = rdata_q;
        addr_err_d = addr_err_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    mar_d      = addr_in[ADDR_W-1:0];
                    wdata_d    = wdata;
                    op_d       = we;
                    addr_err_d = 1'b0;
                    if (addr_oor_s) begin
                        state_d = S_ERR;
                    end else if (NO_WAIT) begin
                        state_d = S_ACCESS;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACCESS: begin
                if (!op_q) begin
                    rdata_d = ram_rdata;
                end else begin
                    rdata_d = rdata_q;
                end
                state_d = S_DONE;
            end
            S_ERR: begin
                addr_err_d = 1'b1;
                state_d    = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and register update; status/strobe outputs are registered from next state.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            mar_q       <= '0;
            wdata_q     <= '0;
            op_q        <= 1'b0;
            rdata_q     <= '0;
            addr_err_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ram_read_q  <= 1'b0;
            ram_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mar_q       <= mar_d;
            wdata_q     <= wdata_d;
            op_q        <= op_d;
            rdata_q     <= rdata_d;
            addr_err_q  <= addr_err_d;
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE);
            ram_read_q  <= (state_d == S_ACCESS) && !op_d;
            ram_write_q <= (state_d == S_ACCESS) && op_d;
        end
    end

    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign addr_err  = addr_err_q;
    assign ram_read  = ram_read_q;
    assign ram_write = ram_write_q;
    assign ram_addr  = mar_q;
    assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (0 and 3 wait states) share stimulus,
// each with its own RAM; a transaction-level model is compared every cycle.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        clr, req, we, preload;
    logic [31:0] addr_in, wdata;

    logic [1:0]        busy_s, done_s, addr_err_s, ram_read_s, ram_write_s;
    logic [1:0][31:0]  rdata_s, ram_wdata_s, ram_rdata_s;
    logic [1:0][8:0]   ram_addr_s;
    logic [31:0]       mem [2][512];

    int n_cmp  = 0;
    int n_fail = 0;
    logic check_en = 1'b0;

    // behavioural model state, one entry per instance
    logic        m_active [2];
    int          m_t      [2];
    logic        m_err    [2];
    logic        m_we     [2];
    logic [8:0]  m_mar    [2];
    logic [31:0] m_wreg   [2];
    logic [31:0] m_rdata  [2];
    logic        m_aerr   [2];

    logic [1:0][7:0] rd_m, wr_m, dn_m, bz_m;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .clr(clr), .req(req), .we(we), .addr_in(addr_in), .wdata(wdata),
        .rdata(rdata_s[0]), .busy(busy_s[0]), .done(done_s[0]), .addr_err(addr_err_s[0]),
        .ram_read(ram_read_s[0]), .ram_write(ram_write_s[0]), .ram_addr(ram_addr_s[0]),
        .ram_wdata(ram_wdata_s[0]), .ram_rdata(ram_rdata_s[0]));

    mem_access_ctrl #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .clr(clr), .req(req), .we(we), .addr_in(addr_in), .wdata(wdata),
        .rdata(rdata_s[1]), .busy(busy_s[1]), .done(done_s[1]), .addr_err(addr_err_s[1]),
        .ram_read(ram_read_s[1]), .ram_write(ram_write_s[1]), .ram_addr(ram_addr_s[1]),
        .ram_wdata(ram_wdata_s[1]), .ram_rdata(ram_rdata_s[1]));

    assign ram_rdata_s[0] = mem[0][ram_addr_s[0]];
    assign ram_rdata_s[1] = mem[1][ram_addr_s[1]];

    // RAM: synchronous write ignored while Read is high, no reset
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (preload) begin
                mem[k][9'h068] <= 32'h0000_0055;
                mem[k][9'h052] <= 32'h0000_0026;
            end else if (ram_write_s[k] && !ram_read_s[k]) begin
                mem[k][ram_addr_s[k]] <= ram_wdata_s[k];
            end
        end
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[inst%0d] t=%0t: got %h, expected %h", nm, k, $time, act, exp);
        end
    endtask

    function automatic int wait_of(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    function automatic int len_of(input int k);
        return m_err[k] ? 2 : wait_of(k) + 2;
    endfunction

    // model: a transaction occupies cycles t = 0 .. len-1 after its acceptance edge
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (clr) begin
                m_active[k] = 1'b0; m_t[k] = 0; m_err[k] = 1'b0; m_we[k] = 1'b0;
                m_mar[k] = 9'd0; m_wreg[k] = 32'd0; m_rdata[k] = 32'd0; m_aerr[k] = 1'b0;
            end else if (m_active[k]) begin
                if (!m_err[k] && !m_we[k] && m_t[k] == wait_of(k)) m_rdata[k] = mem[k][m_mar[k]];
                if (m_err[k] && m_t[k] == 0) m_aerr[k] = 1'b1;
                m_t[k]++;
                if (m_t[k] == len_of(k)) m_active[k] = 1'b0;
            end else if (req) begin
                m_mar[k]    = addr_in[8:0];
                m_wreg[k]   = wdata;
                m_we[k]     = we;
                m_err[k]    = (addr_in >= 32'd512);
                m_aerr[k]   = 1'b0;
                m_active[k] = 1'b1;
                m_t[k]      = 0;
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_active[k] = 1'b0; m_t[k] = 0; m_err[k] = 1'b0; m_we[k] = 1'b0;
            m_mar[k] = 9'd0; m_wreg[k] = 32'd0; m_rdata[k] = 32'd0; m_aerr[k] = 1'b0;
        end
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (check_en) begin
                for (int k = 0; k < 2; k++) begin
                    logic acc;
                    acc = m_active[k] && !m_err[k] && (m_t[k] == wait_of(k));
                    chk("busy",      k, {31'd0, busy_s[k]},      {31'd0, m_active[k]});
                    chk("done",      k, {31'd0, done_s[k]},      {31'd0, m_active[k] && (m_t[k] == len_of(k) - 1)});
                    chk("ram_read",  k, {31'd0, ram_read_s[k]},  {31'd0, acc && !m_we[k]});
                    chk("ram_write", k, {31'd0, ram_write_s[k]}, {31'd0, acc && m_we[k]});
                    chk("addr_err",  k, {31'd0, addr_err_s[k]},  {31'd0, m_aerr[k]});
                    chk("ram_addr",  k, {23'd0, ram_addr_s[k]},  {23'd0, m_mar[k]});
                    chk("ram_wdata", k, ram_wdata_s[k],          m_wreg[k]);
                    chk("rdata",     k, rdata_s[k],              m_rdata[k]);
                end
            end
        end
    end

    // one request, then 8 recorded cycles; extra req pulses (to 0x068) and clr per cycle mask
    task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [7:0] extra_req, input logic [7:0] clr_mask);
        @(negedge clk);
        req = 1'b1; we = w; addr_in = a; wdata = d; clr = 1'b0;
        rd_m = '0; wr_m = '0; dn_m = '0; bz_m = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                rd_m[k][i] = ram_read_s[k];
                wr_m[k][i] = ram_write_s[k];
                dn_m[k][i] = done_s[k];
                bz_m[k][i] = busy_s[k];
            end
            req = extra_req[i]; we = 1'b0; addr_in = 32'h0000_0068; clr = clr_mask[i];
        end
        req = 1'b0; clr = 1'b0;
    endtask

    initial begin
        clr = 1'b1; preload = 1'b1; req = 1'b0; we = 1'b0; addr_in = 32'd0; wdata = 32'd0;
        repeat (3) @(negedge clk);
        clr = 1'b0; preload = 1'b0;
        @(negedge clk);
        check_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_busy",  k, {31'd0, busy_s[k]}, 32'd0);
            chk("rst_rdata", k, rdata_s[k], 32'd0);
            chk("rst_aerr",  k, {31'd0, addr_err_s[k]}, 32'd0);
        end

        run_txn(1'b0, 32'h0000_0068, 32'd0, 8'h00, 8'h00);
        chk("rd_strobe", 0, {24'd0, rd_m[0]}, 32'h01);
        chk("rd_done",   0, {24'd0, dn_m[0]}, 32'h02);
        chk("rd_busy",   0, {24'd0, bz_m[0]}, 32'h03);
        chk("rd_strobe", 1, {24'd0, rd_m[1]}, 32'h08);
        chk("rd_done",   1, {24'd0, dn_m[1]}, 32'h10);
        chk("rd_busy",   1, {24'd0, bz_m[1]}, 32'h1F);
        chk("rd_data",   0, rdata_s[0], 32'h0000_0055);
        chk("rd_data",   1, rdata_s[1], 32'h0000_0055);

        run_txn(1'b1, 32'h0000_01F0, 32'h1234_5678, 8'h00, 8'h00);
        chk("wr_strobe",  0, {24'd0, wr_m[0]}, 32'h01);
        chk("wr_nord",    0, {24'd0, rd_m[0]}, 32'h00);
        chk("wr_strobe",  1, {24'd0, wr_m[1]}, 32'h08);
        chk("wr_keep_rd", 0, rdata_s[0], 32'h0000_0055);

        run_txn(1'b0, 32'h0000_01F0, 32'd0, 8'h00, 8'h00);
        chk("rdback", 0, rdata_s[0], 32'h1234_5678);
        chk("rdback", 1, rdata_s[1], 32'h1234_5678);

        run_txn(1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 8'h00, 8'h00);
        for (int k = 0; k < 2; k++) begin
            chk("oor_strobes", k, {16'd0, rd_m[k], wr_m[k]}, 32'd0);
            chk("oor_done",    k, {24'd0, dn_m[k]}, 32'h02);
            chk("oor_aerr",    k, {31'd0, addr_err_s[k]}, 32'd1);
            chk("oor_rdata",   k, rdata_s[k], 32'h1234_5678);
        end

        run_txn(1'b0, 32'h0000_0052, 32'd0, 8'h03, 8'h00);
        chk("bsy_done",   0, {24'd0, dn_m[0]}, 32'h02);
        chk("bsy_strobe", 0, {24'd0, rd_m[0]}, 32'h01);
        chk("bsy_done",   1, {24'd0, dn_m[1]}, 32'h10);
        chk("bsy_strobe", 1, {24'd0, rd_m[1]}, 32'h08);
        for (int k = 0; k < 2; k++) begin
            chk("bsy_rdata", k, rdata_s[k], 32'h0000_0026);
            chk("bsy_aerr",  k, {31'd0, addr_err_s[k]}, 32'd0);
        end

        run_txn(1'b0, 32'h0000_0068, 32'd0, 8'h00, 8'h02);
        chk("clr_strobe", 1, {24'd0, rd_m[1]}, 32'h00);
        chk("clr_done",   1, {24'd0, dn_m[1]}, 32'h00);
        chk("clr_busy",   1, {24'd0, bz_m[1]}, 32'h03);
        chk("clr_rdata",  0, rdata_s[0], 32'd0);
        chk("clr_rdata",  1, rdata_s[1], 32'd0);

        run_txn(1'b0, 32'h0000_0068, 32'd0, 8'h00, 8'h00);
        chk("post_clr_done",  1, {24'd0, dn_m[1]}, 32'h10);
        chk("post_clr_rdata", 1, rdata_s[1], 32'h0000_0055);

        // randomized traffic; the per-cycle model comparison does the checking
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            req   = ($urandom_range(0, 2) == 0);
            we    = $urandom_range(0, 1) == 1;
            wdata = $urandom;
            if ($urandom_range(0, 7) == 0)
                addr_in = $urandom | (32'd1 << $urandom_range(9, 31));
            else
                addr_in = 32'($urandom_range(0, 511));
            clr = ($urandom_range(0, 79) == 0);
        end
        @(negedge clk);
        req = 1'b0; clr = 1'b0;
        repeat (8) @(negedge clk);
        check_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
